// File: rtl/qkd_pkg.sv
// ---------------------------------------------------------------------------
// qkd_pkg
// Shared constants, FSM state type and CRC-8 helper for the QKD key
// serializer slice (qkd_key_fifo, qkd_key_serializer).
//   KEY_W / BYTE_W   default key and output byte widths
//   BYTES_PER_KEY    bytes per key frame (without optional CRC trailer)
//   state_e          serializer FSM states
//   CRC8_POLY        CRC-8 polynomial used when QKD_KEY_CRC_EN is defined
// ---------------------------------------------------------------------------
package qkd_pkg;

   localparam int KEY_W         = 128;
   localparam int BYTE_W        = 8;
   localparam int BYTES_PER_KEY = KEY_W / BYTE_W;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_e;

   localparam logic [7:0] CRC8_POLY = 8'h07;

   // One byte of CRC-8, MSB-first, no reflection.
   function automatic logic [7:0] crc8_byte(input logic [7:0] crc,
                                            input logic [7:0] data);
      logic [7:0] c;
      c = crc ^ data;
      for (int i = 0; i < 8; i++) begin
         c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
      end
      return c;
   endfunction

endpackage

// File: rtl/qkd_key_fifo.sv
// ---------------------------------------------------------------------------
// qkd_key_fifo
// Key-wide circular FIFO with registered count and registered not-full flag.
// Write is synchronous, read data is the current head (show-ahead).
// Ports:
//   clk, rst           clock, asynchronous active-low reset
//   i_wr_en, i_wr_data push a key (caller guarantees !full)
//   i_rd_en            pop the head (caller guarantees !empty)
//   o_rd_data          head entry
//   o_empty            no entries
//   o_not_full         registered !full; 0 while in reset
//   o_count            number of entries
// ---------------------------------------------------------------------------
module qkd_key_fifo #(
   parameter int W     = 128,
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_wr_en,
   input  logic [W-1:0]               i_wr_data,
   input  logic                       i_rd_en,
   output logic [W-1:0]               o_rd_data,
   output logic                       o_empty,
   output logic                       o_not_full,
   output logic [$clog2(DEPTH):0]     o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          r_not_full;
   logic [CW-1:0] w_count_nxt;

   always_comb begin
      w_count_nxt = r_count;
      if (i_wr_en && !i_rd_en) begin
         w_count_nxt = r_count + 1'b1;
      end else if (!i_wr_en && i_rd_en) begin
         w_count_nxt = r_count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_mem[r_wr_ptr] <= i_wr_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_not_full <= 1'b0;
      end else begin
         if (i_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (i_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count    <= w_count_nxt;
         r_not_full <= (w_count_nxt != CW'(DEPTH));
      end
   end

   assign o_rd_data  = r_mem[r_rd_ptr];
   assign o_empty    = (r_count == '0);
   assign o_not_full = r_not_full;
   assign o_count    = r_count;

endmodule

// File: rtl/qkd_key_serializer.sv
// ---------------------------------------------------------------------------
// qkd_key_serializer
// Buffers completed final keys (FIFO_DEPTH entries plus the key being
// streamed) and emits each one MSB-first as a byte frame with a per-key ID.
// Build option: QKD_KEY_CRC_EN appends a CRC-8 (poly 0x07, init 0) trailer
// byte; out_last then marks the trailer and the frame is one byte longer.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; once out_valid is raised, out_data/out_last/out_key_id hold
// until accepted and out_valid does not drop before acceptance.
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   key_in/valid    incoming key; key_ready = FIFO not full (registered)
//   out_data/valid/ready/last  byte stream to the key consumer
//   out_key_id      ID of the frame being streamed
//   zero_key_drop   pulse: an all-zero key was accepted and discarded
//   fifo_count      keys buffered, excluding the key being streamed
//   dbg_state       FSM state
// ---------------------------------------------------------------------------
module qkd_key_serializer
   import qkd_pkg::*;
#(
   parameter int KEY_W      = qkd_pkg::KEY_W,
   parameter int BYTE_W     = qkd_pkg::BYTE_W,
   parameter int FIFO_DEPTH = 2,
   parameter int ID_W       = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [KEY_W-1:0]              key_in,
   input  logic                          key_valid,
   output logic                          key_ready,
   output logic [BYTE_W-1:0]             out_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic                          out_last,
   output logic [ID_W-1:0]               out_key_id,
   output logic                          zero_key_drop,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output state_e                        dbg_state
);

   localparam int N_KEY_BYTES = KEY_W / BYTE_W;
`ifdef QKD_KEY_CRC_EN
   localparam int N_FRAME = N_KEY_BYTES + 1;
`else
   localparam int N_FRAME = N_KEY_BYTES;
`endif
   localparam int CNT_W = $clog2(N_FRAME);

   state_e              r_state;
   logic [KEY_W-1:0]    r_shift;
   logic [CNT_W-1:0]    r_cnt;
   logic [ID_W-1:0]     r_id;
   logic                r_valid;
   logic                r_last;
   logic                r_zero_drop;
`ifdef QKD_KEY_CRC_EN
   logic [7:0]          r_crc;
`endif

   logic                w_accept;
   logic                w_zero;
   logic                w_wr;
   logic                w_byte_acc;
   logic                w_frame_end;
   logic                w_pop;
   logic                w_fifo_empty;
   logic [KEY_W-1:0]    w_fifo_rd_data;

   assign w_accept    = key_valid && key_ready;
   assign w_zero      = (key_in == '0);
   assign w_wr        = w_accept && !w_zero;
   assign w_byte_acc  = r_valid && out_ready;
   assign w_frame_end = w_byte_acc && r_last;
   // Pop when idle, or right as the last byte leaves so frames run back to back.
   assign w_pop       = !w_fifo_empty && ((r_state == IDLE) || w_frame_end);

   qkd_key_fifo #(
      .W     (KEY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .i_wr_en    (w_wr),
      .i_wr_data  (key_in),
      .i_rd_en    (w_pop),
      .o_rd_data  (w_fifo_rd_data),
      .o_empty    (w_fifo_empty),
      .o_not_full (key_ready),
      .o_count    (fifo_count)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= IDLE;
         r_shift     <= '0;
         r_cnt       <= '0;
         r_id        <= '0;
         r_valid     <= 1'b0;
         r_last      <= 1'b0;
         r_zero_drop <= 1'b0;
`ifdef QKD_KEY_CRC_EN
         r_crc       <= '0;
`endif
      end else begin
         r_zero_drop <= w_accept && w_zero;
         if (w_frame_end) begin
            r_id <= r_id + 1'b1;
         end
         if (w_pop) begin
            r_shift <= w_fifo_rd_data;
            r_cnt   <= '0;
            r_valid <= 1'b1;
            r_last  <= 1'b0;
            r_state <= SEND;
`ifdef QKD_KEY_CRC_EN
            r_crc   <= '0;
`endif
         end else if (w_frame_end) begin
            r_shift <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_state <= IDLE;
         end else if (w_byte_acc) begin
            r_shift <= r_shift << BYTE_W;
            r_cnt   <= r_cnt + 1'b1;
            // Byte index N_FRAME-2 is being accepted, so the next one is last.
            r_last  <= (r_cnt == CNT_W'(N_FRAME - 2));
`ifdef QKD_KEY_CRC_EN
            r_crc   <= crc8_byte(r_crc, r_shift[KEY_W-1 -: 8]);
`endif
         end
      end
   end

`ifdef QKD_KEY_CRC_EN
   assign out_data = r_last ? BYTE_W'(r_crc) : r_shift[KEY_W-1 -: BYTE_W];
`else
   assign out_data = r_shift[KEY_W-1 -: BYTE_W];
`endif
   assign out_valid     = r_valid;
   assign out_last      = r_last;
   assign out_key_id    = r_id;
   assign zero_key_drop = r_zero_drop;
   assign dbg_state     = r_state;

endmodule
